// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  // Two write ports; port 1 has priority over port 0 on an address clash.
  localparam int REGFILE_NWRITE = 2;

  // Clear sequencer states.
  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;

  // Address width for a given register count (at least one bit).
  function automatic int rf_aw(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write/read bus of the register file, shared by the core and the array.
interface regfile_mp_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NREAD = 2
);
  import regfile_pkg::*;

  localparam int AW = rf_aw(DEPTH);

  logic [REGFILE_NWRITE-1:0]       we;
  logic [REGFILE_NWRITE*AW-1:0]    wa;
  logic [REGFILE_NWRITE*WIDTH-1:0] wd;
  logic [NREAD*AW-1:0]             ra;
  logic [NREAD*WIDTH-1:0]          rd;
  logic                            ready;

  modport master (output we, wa, wd, ra, input rd, ready);
  modport slave  (input we, wa, wd, ra, output rd, ready);

endinterface

// File: rtl/regfile_clr_seq.sv
// Post-reset clear sequencer: walks every entry once, then enables the array.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = rf_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          clr_en_o,
  output logic [AW-1:0] clr_addr_o,
  output logic          ready_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // State and clear-counter registers; any reset restarts the clear from entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: one entry cleared per cycle, RUN once the last entry is written.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_en_o = 1'b0;
    case (state_q)
      RF_CLEAR: begin
        clr_en_o = !reset;
        if (cnt_q == LAST) begin
          state_d = RF_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign clr_addr_o = cnt_q;
  // Reset forces ready low in the same cycle, even before the state register updates.
  assign ready_o    = (state_q == RF_RUN) && !reset;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: two prioritised write ports, NREAD combinational
// read ports with optional same-cycle write forwarding, cleared after reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);

  localparam int AW = rf_aw(DEPTH);
  // One extra bit so the range check stays meaningful when DEPTH is a power of 2.
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic                      clr_en;
  logic [AW-1:0]             clr_addr;
  logic                      ready;
  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [REGFILE_NWRITE-1:0] wr_ok;
  logic [AW-1:0]             wa_w [REGFILE_NWRITE];
  logic [WIDTH-1:0]          wd_w [REGFILE_NWRITE];

  regfile_clr_seq #(.DEPTH(DEPTH), .AW(AW)) u_clr_seq (
    .clk        (clk),
    .reset      (reset),
    .clr_en_o   (clr_en),
    .clr_addr_o (clr_addr),
    .ready_o    (ready)
  );

  assign bus.ready = ready;

  genvar gi;

  // A write is taken only in RUN, in range, and never into a hard-wired zero register.
  generate
    for (gi = 0; gi < REGFILE_NWRITE; gi++) begin : g_wr
      assign wa_w[gi]  = bus.wa[gi*AW +: AW];
      assign wd_w[gi]  = bus.wd[gi*WIDTH +: WIDTH];
      assign wr_ok[gi] = ready && bus.we[gi] && ({1'b0, wa_w[gi]} < DEPTH_W)
                         && !((ZERO_REG != 0) && (wa_w[gi] == '0));
    end
  endgenerate

  // Array update: clear sweep, else writes in port order so port 1 lands last.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_q[clr_addr] <= '0;
    end else begin
      for (int k = 0; k < REGFILE_NWRITE; k++) begin
        if (wr_ok[k]) mem_q[wa_w[k]] <= wd_w[k];
      end
    end
  end

  // Read ports: zero when not ready / out of range / zero register, then forwarding, then array.
  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [AW-1:0]    ra_w;
      logic [WIDTH-1:0] rd_w;

      assign ra_w = bus.ra[gi*AW +: AW];

      // Priority mux for this read port.
      always_comb begin
        rd_w = '0;
        if (!ready || !({1'b0, ra_w} < DEPTH_W) || ((ZERO_REG != 0) && (ra_w == '0))) begin
          rd_w = '0;
        end else if ((BYPASS != 0) && bus.we[1] && (wa_w[1] == ra_w)) begin
          rd_w = wd_w[1];
        end else if ((BYPASS != 0) && bus.we[0] && (wa_w[0] == ra_w)) begin
          rd_w = wd_w[0];
        end else begin
          rd_w = mem_q[ra_w];
        end
      end

      assign bus.rd[gi*WIDTH +: WIDTH] = rd_w;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two configurations driven with identical stimulus and
// compared each cycle against an array-level model of the register file.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Config 0: defaults. Config 1: 24 entries, 3 read ports, no zero reg, no bypass.
  regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NREAD(2)) bus_a ();
  regfile_mp_if #(.WIDTH(32), .DEPTH(24), .NREAD(3)) bus_b ();

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  regfile_mp #(.WIDTH(32), .DEPTH(24), .NREAD(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));

  int checks = 0;
  int errors = 0;
  int lo_a = 0;
  int lo_b = 0;

  // Stimulus for the current cycle.
  logic [1:0]  we_v;
  logic [4:0]  wa_v [2];
  logic [31:0] wd_v [2];
  logic [4:0]  ra_v [3];

  // Model: 32 cells per config; cells beyond a config's depth stay 0 forever.
  logic [31:0] mdl [2][32];
  int          edges = 0;    // non-reset clock edges since the last reset edge
  int          depth_c [2] = '{32, 24};
  bit          zero_c  [2] = '{1'b1, 1'b0};
  bit          byp_c   [2] = '{1'b1, 1'b0};
  int          nrd_c   [2] = '{2, 3};

  function automatic bit exp_ready(int c);
    return !reset && (edges >= depth_c[c]);
  endfunction

  // Contents of a cell once this cycle's writes (if accepted) have landed.
  function automatic logic [31:0] next_val(int c, int addr);
    logic [31:0] v = mdl[c][addr];
    for (int k = 0; k < 2; k++)
      if (we_v[k] && int'(wa_v[k]) == addr && addr < depth_c[c] && !(zero_c[c] && addr == 0))
        v = wd_v[k];
    return v;
  endfunction

  function automatic logic [31:0] exp_rd(int c, int p);
    if (!exp_ready(c)) return 32'h0;
    return byp_c[c] ? next_val(c, int'(ra_v[p])) : mdl[c][ra_v[p]];
  endfunction

  function automatic logic [31:0] obs_rd(int c, int p);
    if (c == 0) return bus_a.rd[p*32 +: 32];
    return bus_b.rd[p*32 +: 32];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus_a.we = we_v;
    bus_a.wa = {wa_v[1], wa_v[0]};
    bus_a.wd = {wd_v[1], wd_v[0]};
    bus_a.ra = {ra_v[1], ra_v[0]};
    bus_b.we = we_v;
    bus_b.wa = {wa_v[1], wa_v[0]};
    bus_b.wd = {wd_v[1], wd_v[0]};
    bus_b.ra = {ra_v[2], ra_v[1], ra_v[0]};
  endtask

  task automatic check_all();
    chk("ready_a", {31'h0, bus_a.ready}, {31'h0, exp_ready(0)});
    chk("ready_b", {31'h0, bus_b.ready}, {31'h0, exp_ready(1)});
    if (!reset && bus_a.ready === 1'b0) lo_a++;
    if (!reset && bus_b.ready === 1'b0) lo_b++;
    for (int c = 0; c < 2; c++)
      for (int p = 0; p < nrd_c[c]; p++)
        chk($sformatf("rd%0d_%s ra=%0d", p, (c == 0) ? "a" : "b", ra_v[p]), obs_rd(c, p), exp_rd(c, p));
    $display("t=%0t rst=%0b we=%b wa=%0d/%0d ra=%0d/%0d/%0d rdy=%0b/%0b a.rd0=%h b.rd0=%h",
             $time, reset, we_v, wa_v[0], wa_v[1], ra_v[0], ra_v[1], ra_v[2],
             bus_a.ready, bus_b.ready, bus_a.rd[31:0], bus_b.rd[31:0]);
  endtask

  task automatic update_model();
    if (reset) begin
      edges = 0;
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 32; a++) mdl[c][a] = 32'h0;
    end else begin
      for (int c = 0; c < 2; c++)
        if (edges >= depth_c[c])
          for (int a = 0; a < 32; a++) mdl[c][a] = next_val(c, a);
      edges++;
    end
  endtask

  task automatic step_pre();
    drive();
    #2;
    check_all();
  endtask

  task automatic step_post();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic step();
    step_pre();
    step_post();
  endtask

  task automatic rand_in(input bit allow_we);
    we_v = allow_we ? 2'($urandom_range(0, 3)) : 2'b00;
    for (int k = 0; k < 2; k++) begin
      wa_v[k] = 5'($urandom_range(0, 31));
      wd_v[k] = $urandom;
    end
    for (int p = 0; p < 3; p++) ra_v[p] = 5'($urandom_range(0, 31));
    if ($urandom_range(0, 3) == 0) ra_v[0] = wa_v[1];
    if ($urandom_range(0, 3) == 0) ra_v[1] = wa_v[0];
  endtask

  task automatic set_ra(input logic [4:0] a);
    for (int p = 0; p < 3; p++) ra_v[p] = a;
  endtask

  initial begin
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 32; a++) mdl[c][a] = 32'h0;

    // Reset held for 3 cycles, random traffic applied meanwhile.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_in(1'b1); step(); end

    // Release: writes during CLEAR must vanish; count ready-low cycles.
    reset = 1'b0;
    lo_a = 0; lo_b = 0;
    for (int i = 0; i < 20; i++) begin rand_in(1'b1); step(); end
    for (int i = 0; i < 20; i++) begin rand_in(1'b0); step(); end
    chk("ready_low_cycles_a", 32'(lo_a), 32'd32);
    chk("ready_low_cycles_b", 32'(lo_b), 32'd24);

    // Single write to 5 with same-cycle read.
    we_v = 2'b01; wa_v[0] = 5'd5; wa_v[1] = 5'd9; wd_v[0] = 32'hDEADBEEF; wd_v[1] = 32'h0;
    set_ra(5'd5);
    step_pre();
    chk("bypass_a_rd1", bus_a.rd[63:32], 32'hDEADBEEF);
    chk("nobypass_b_rd1", bus_b.rd[63:32], 32'h0);
    step_post();
    we_v = 2'b00;
    step_pre();
    chk("after_wr_a", bus_a.rd[31:0], 32'hDEADBEEF);
    chk("after_wr_b", bus_b.rd[31:0], 32'hDEADBEEF);
    step_post();

    // Both ports to 7: port 1 wins.
    we_v = 2'b11; wa_v[0] = 5'd7; wa_v[1] = 5'd7; wd_v[0] = 32'h1111; wd_v[1] = 32'h2222;
    set_ra(5'd7);
    step_pre();
    chk("clash_bypass_a", bus_a.rd[31:0], 32'h2222);
    step_post();
    we_v = 2'b00;
    step_pre();
    chk("clash_a", bus_a.rd[31:0], 32'h2222);
    chk("clash_b", bus_b.rd[31:0], 32'h2222);
    step_post();

    // Write to register 0.
    we_v = 2'b01; wa_v[0] = 5'd0; wd_v[0] = 32'hFFFFFFFF;
    set_ra(5'd0);
    step_pre();
    chk("zero_same_a", bus_a.rd[31:0], 32'h0);
    step_post();
    we_v = 2'b00;
    step_pre();
    chk("zero_next_a", bus_a.rd[31:0], 32'h0);
    chk("nozero_next_b", bus_b.rd[31:0], 32'hFFFFFFFF);
    step_post();

    // Address 27: out of range for the 24-entry config.
    we_v = 2'b01; wa_v[0] = 5'd27; wd_v[0] = 32'h12345678;
    set_ra(5'd27);
    step();
    we_v = 2'b00;
    step_pre();
    chk("oor_b", bus_b.rd[31:0], 32'h0);
    chk("inrange_a", bus_a.rd[31:0], 32'h12345678);
    step_post();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin rand_in(1'b1); step(); end

    // Fill 1..31 with i*3.
    for (int i = 1; i < 32; i++) begin
      we_v = 2'b01; wa_v[0] = 5'(i); wd_v[0] = 32'(i * 3); wa_v[1] = 5'd0;
      set_ra(5'($urandom_range(0, 31)));
      step();
    end

    // Reset, 10 clear steps, reset again mid-clear, writes throughout.
    reset = 1'b1; rand_in(1'b1); step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin rand_in(1'b1); step(); end
    reset = 1'b1; rand_in(1'b1); step();
    reset = 1'b0;
    lo_a = 0; lo_b = 0;
    for (int i = 0; i < 20; i++) begin rand_in(1'b1); step(); end
    for (int i = 0; i < 20; i++) begin rand_in(1'b0); step(); end
    chk("reclear_low_cycles_a", 32'(lo_a), 32'd32);
    chk("reclear_low_cycles_b", 32'(lo_b), 32'd24);

    // Every register reads 0 after the restarted clear.
    we_v = 2'b00;
    for (int a = 0; a < 32; a++) begin
      set_ra(5'(a));
      step_pre();
      chk($sformatf("cleared_a_%0d", a), bus_a.rd[31:0], 32'h0);
      chk($sformatf("cleared_b_%0d", a), bus_b.rd[31:0], 32'h0);
      step_post();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
